// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - data-memory port bundle for the UART transmitter window
//
// Purpose: groups the core's port-B dmem signals seen by uart_tx_mmio.
// Signals:
//   addr     [31:0] byte address          (master -> slave)
//   data_i   [31:0] write data            (master -> slave)
//   data_en  [3:0]  byte-lane enables     (master -> slave)
//   write_en        write strobe          (master -> slave)
//   data_o   [31:0] registered read data  (slave -> master)
`timescale 1ns/1ps

interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [3:0]  data_en;
  logic        write_en;
  logic [31:0] data_o;

  modport master (output addr, output data_i, output data_en, output write_en, input data_o);
  modport slave  (input addr, input data_i, input data_en, input write_en, output data_o);
endinterface

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with TX FIFO (8N1, 8E1 with UART_TX_PARITY_EN)
//
// Purpose: TXDATA (+0) stores push bytes into a FIFO, a bit-timing FSM
// serialises them onto tx. STATUS (+4) reads back full/empty/busy/overflow
// and occupancy with one-cycle latency; writing bit3 of STATUS clears overflow.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
// Ports:
//   clk        core clock
//   reset      asynchronous active-low reset
//   bus        dmem port (uart_tx_mmio_if.slave)
//   tx         serial output, idle high
//   busy       frame on the wire or FIFO non-empty
//   fifo_full  FIFO holds FIFO_DEPTH entries
`timescale 1ns/1ps

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          CLKS_PER_BIT = 543,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_TC = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [31:0]   data_o_q;

  logic          hit, wr_txdata, wr_status, push, pop, fifo_empty, bit_tc;
  logic [7:0]    push_byte;
  logic [31:0]   status;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign hit        = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata  = bus.write_en & hit & ~bus.addr[2];
  assign wr_status  = bus.write_en & hit & bus.addr[2];
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Fullness is judged on registered count, so a same-cycle pop never rescues a push.
  assign push       = wr_txdata & ~fifo_full;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign busy       = (state_q != S_IDLE) | ~fifo_empty;
  assign bit_tc     = (baud_q == BAUD_TC);
  assign bus.data_o = data_o_q;

  // Only a clean one-hot lane enable selects an upper byte; anything else falls back to lane 0.
  always_comb begin
    case (bus.data_en)
      4'b0010: push_byte = bus.data_i[15:8];
      4'b0100: push_byte = bus.data_i[23:16];
      4'b1000: push_byte = bus.data_i[31:24];
      default: push_byte = bus.data_i[7:0];
    endcase
  end

  assign status = {16'h0, 8'(count_q), 4'h0, overflow_q, busy, fifo_empty, fifo_full};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_o_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_txdata && fifo_full)          overflow_q <= 1'b1;
      else if (wr_status && bus.data_i[3]) overflow_q <= 1'b0;
      data_o_q <= (hit && bus.addr[2]) ? status : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Baud counter defaults to reload; it only advances while a bit is still being held.
  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_tc) state_d = S_DATA;
        else        baud_d  = baud_q + 16'd1;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_tc) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx = parity_q;
        if (bit_tc) state_d = S_STOP;
        else        baud_d  = baud_q + 16'd1;
      end
`endif
      S_STOP: begin
        tx = 1'b1;
        if (bit_tc) state_d = S_IDLE;
        else        baud_d  = baud_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
`timescale 1ns/1ps

module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy, fifo_full;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int w_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial receiver: samples each bit near its middle.
  logic [7:0] rx_q [$];
  logic       rx_par_q [$];
  int         rx_err = 0;
  logic [7:0] rx_b;
  logic       rx_p;

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        @(negedge clk);
        if (tx !== 1'b0) rx_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = tx;
        end
        rx_p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        rx_p = tx;
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) rx_err++;
        rx_q.push_back(rx_b);
        rx_par_q.push_back(rx_p);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge; each consumes one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    bus.addr = a; bus.data_i = d; bus.data_en = e; bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0; bus.addr = 32'h0;
    w_cyc = cyc;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.write_en = 1'b0;
    @(negedge clk);
    d = bus.data_o;
    bus.addr = 32'h0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Expected wire image, bit k is what tx shows during the k-th bit period.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [31:0] status_word(input int occ, input logic ovf, input logic bsy);
    return {16'h0, 8'(occ), 4'h0, ovf, bsy, (occ == 0), (occ == DEPTH)};
  endfunction

  // Called right after a write into an idle, empty transmitter.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [NBITS-1:0] fb;
    fb = frame_bits(b);
    chk({tag, "_pre_idle"}, tx, 1'b1);
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0) @(negedge clk);
      else        repeat (CPB) @(negedge clk);
      chk($sformatf("%s_bit%0d", tag, k), tx, fb[k]);
    end
    wait_idle(4 * FRAME);
    chk({tag, "_busy_drop"}, busy, 1'b0);
    chk({tag, "_frame_len"}, cyc - w_cyc, 1 + FRAME);
    chk({tag, "_rx_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({tag, "_rx_byte"}, rx_q.pop_front(), b);
    if (rx_par_q.size() > 0) begin
`ifdef UART_TX_PARITY_EN
      chk({tag, "_rx_parity"}, rx_par_q.pop_front(), ^b);
`else
      void'(rx_par_q.pop_front());
`endif
    end
  endtask

  logic [31:0] rdata;
  logic [3:0]  en_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1111, 4'b0110};
  logic [7:0]  b;
  logic [3:0]  en;
  logic [31:0] d;
  int          accepted, occ, lows;
  logic        ovf;

  initial begin
    bus.addr = 32'h0; bus.data_i = 32'h0; bus.data_en = 4'h0; bus.write_en = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_data_o", bus.data_o, 32'h0);
    reset = 1'b1;

    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("idle_100_cycles", lows, 0);
    rd(BASE + 4, rdata);           chk("status_after_reset", rdata, 32'h0000_0002);
    rd(BASE + 0, rdata);           chk("txdata_read", rdata, 32'h0);
    rd(BASE + 8, rdata);           chk("miss_read_adjacent", rdata, 32'h0);
    rd(BASE ^ 32'h1000_0004, rdata); chk("miss_read_far", rdata, 32'h0);

    wr(BASE + 8, 32'h0000_0012, 4'b0001);
    repeat (3) @(negedge clk);
    chk("miss_write_busy", busy, 1'b0);
    rd(BASE + 4, rdata);           chk("miss_write_status", rdata, 32'h0000_0002);

    d = $urandom; d[7:0] = 8'h55;
    wr(BASE, d, 4'b0001);
    check_frame("sb55", 8'h55);

    wr(BASE + 2, 32'h00A3_0000, 4'b0100);
    check_frame("lane2_A3", 8'hA3);

    for (int it = 0; it < 6; it++) begin
      b  = 8'($urandom);
      en = en_tbl[$urandom_range(0, 7)];
      d  = $urandom;
      case (en)
        4'b0010: d[15:8]  = b;
        4'b0100: d[23:16] = b;
        4'b1000: d[31:24] = b;
        default: d[7:0]   = b;
      endcase
      wr(BASE + 32'($urandom_range(0, 3)), d, en);
      check_frame($sformatf("rand%0d", it), b);
    end

    // Burst while idle: the first byte leaves for the shifter at once, DEPTH more are held.
    for (int i = 1; i <= 6; i++) wr(BASE, 32'(i), 4'b0001);
    accepted = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
    occ = accepted - 1;
    ovf = (accepted < 6);
    rd(BASE + 4, rdata);
    chk("burst_status", rdata, status_word(occ, ovf, 1'b1));
    chk("burst_full_pin", fifo_full, (occ == DEPTH));
    wait_idle(accepted * (FRAME + 1) + 20);
    chk("burst_drain", busy, 1'b0);
    chk("burst_rx_count", rx_q.size(), accepted);
    for (int i = 1; i <= accepted; i++) begin
      if (rx_q.size() > 0) chk($sformatf("burst_byte%0d", i), rx_q.pop_front(), 8'(i));
    end
    rx_par_q.delete();
    rd(BASE + 4, rdata);           chk("ovf_sticky", rdata, status_word(0, ovf, 1'b0));
    wr(BASE + 4, 32'h7, 4'hF);
    rd(BASE + 4, rdata);           chk("ovf_not_cleared_bit3_0", rdata, status_word(0, ovf, 1'b0));
    wr(BASE + 4, 32'h8, 4'hF);
    rd(BASE + 4, rdata);           chk("ovf_cleared", rdata, 32'h0000_0002);

`ifdef UART_TX_PARITY_EN
    wr(BASE, 32'h07, 4'b0001);
    check_frame("par07", 8'h07);
    wr(BASE, 32'h03, 4'b0001);
    check_frame("par03", 8'h03);
`endif

    // Reset in the middle of the data bits of 0xFF, with another byte queued.
    wr(BASE, 32'hFF, 4'b0001);
    wr(BASE, 32'h00, 4'b0001);
    repeat (12) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_full", fifo_full, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("post_reset_quiet", lows, 0);
    rx_q.delete();
    rx_par_q.delete();
    rd(BASE + 4, rdata);           chk("post_reset_status", rdata, 32'h0000_0002);
    repeat (50) @(negedge clk);
    chk("post_reset_no_frame", rx_q.size(), 0);

    b = 8'($urandom);
    wr(BASE + 1, {24'h0, b}, 4'b0001);
    check_frame("post_reset_frame", b);

    chk("rx_framing_errors", rx_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
